// File: rtl/match_scan_ctrl_if.sv
// Control/handshake bundle between the host, match_scan_ctrl and the matching datapath.
// MATCH_SCAN_STALL_EN adds the stall input.
interface match_scan_ctrl_if;
  logic       start;
  logic       busy;
  logic       done;
  logic [6:0] vector_xf;
  logic [6:0] vector_xg;
  logic [3:0] vector_y;
  logic [6:0] pix_x;
  logic [3:0] pix_y;
  logic       startsig;
  logic       work;
  logic       valid;
  logic       finalstart;
  logic       update;
`ifdef MATCH_SCAN_STALL_EN
  logic       stall;

  modport master (
    output start, stall,
    input  busy, done, vector_xf, vector_xg, vector_y, pix_x, pix_y,
           startsig, work, valid, finalstart, update
  );

  modport slave (
    input  start, stall,
    output busy, done, vector_xf, vector_xg, vector_y, pix_x, pix_y,
           startsig, work, valid, finalstart, update
  );
`else
  modport master (
    output start,
    input  busy, done, vector_xf, vector_xg, vector_y, pix_x, pix_y,
           startsig, work, valid, finalstart, update
  );

  modport slave (
    input  start,
    output busy, done, vector_xf, vector_xg, vector_y, pix_x, pix_y,
           startsig, work, valid, finalstart, update
  );
`endif
endinterface

// File: rtl/match_scan_ctrl.sv
// Stereo-match sequencer: raster-walks output pixels and scans the correlation window per pixel.
// Optional MATCH_SCAN_STALL_EN: stall input freezes the scan/drain phases.
module match_scan_ctrl #(
  parameter int IMG_W     = 100,
  parameter int IMG_H     = 16,
  parameter int WIN_W     = 5,
  parameter int WIN_H     = 5,
  parameter int NUM_UNITS = 16,
  parameter int MEM_LAT   = 1,
  parameter int TREE_LAT  = 4
) (
  input logic              clk,
  input logic              rst_n,
  match_scan_ctrl_if.slave bus
);

  localparam int C_CNT = WIN_W + NUM_UNITS - 1;
  localparam int CW    = (C_CNT > 1) ? $clog2(C_CNT) : 1;
  localparam int RW    = (WIN_H > 1) ? $clog2(WIN_H) : 1;
  localparam int TMAX  = (MEM_LAT > TREE_LAT) ? MEM_LAT : TREE_LAT;
  localparam int TW    = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [CW-1:0] C_LAST = CW'(C_CNT - 1);
  localparam logic [RW-1:0] R_LAST = RW'(WIN_H - 1);
  localparam logic [6:0]    X_LAST = 7'(IMG_W - WIN_W - NUM_UNITS + 1);
  localparam logic [3:0]    Y_LAST = 4'(IMG_H - WIN_H);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_SCAN  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FINAL = 3'd4;
  localparam logic [2:0] S_TREE  = 3'd5;
  localparam logic [2:0] S_UPD   = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  if (IMG_W < WIN_W + NUM_UNITS - 1 || IMG_H < WIN_H || MEM_LAT < 0 || TREE_LAT < 0 ||
      IMG_W > 128 || IMG_H > 16) begin : g_bad_params
    $error("match_scan_ctrl: illegal parameter combination");
  end

  logic [2:0]    state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [TW-1:0] tcnt;
  logic [6:0]    px;
  logic [3:0]    py;
  logic [6:0]    xf_q;
  logic [6:0]    xg_q;
  logic [3:0]    y_q;

  logic          stall_i;
  logic          freeze;
  logic          col_last;
  logic          cell_last;
  logic [CW-1:0] col_adv;
  logic [RW-1:0] row_adv;
  logic [CW-1:0] a_col;
  logic [RW-1:0] a_row;
  logic          load_addr;
  logic          raw_work;
  logic          raw_valid;
  logic          work_d;
  logic          valid_d;

`ifdef MATCH_SCAN_STALL_EN
  assign stall_i = bus.stall;
`else
  assign stall_i = 1'b0;
`endif

  assign freeze    = stall_i && (state == S_SCAN || state == S_DRAIN);
  assign col_last  = (col == C_LAST);
  assign cell_last = col_last && (row == R_LAST);
  assign col_adv   = col_last ? '0 : col + 1'b1;
  assign row_adv   = col_last ? ((row == R_LAST) ? '0 : row + 1'b1) : row;

  // Address registers present the cell being scanned in the same cycle as raw work,
  // so they are loaded with the upcoming cell (cell 0,0 when leaving START).
  assign a_col     = (state == S_START) ? col : col_adv;
  assign a_row     = (state == S_START) ? row : row_adv;
  assign load_addr = (state == S_START) || (state == S_SCAN && !freeze && !cell_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      col   <= '0;
      row   <= '0;
      tcnt  <= '0;
      px    <= '0;
      py    <= '0;
      xf_q  <= '0;
      xg_q  <= '0;
      y_q   <= '0;
    end else begin
      case (state)
        S_IDLE:  if (bus.start) state <= S_START;
        S_START: state <= S_SCAN;
        S_SCAN: begin
          if (!freeze) begin
            col <= col_adv;
            row <= row_adv;
            if (cell_last) state <= (MEM_LAT == 0) ? S_FINAL : S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!freeze) begin
            if (tcnt == TW'(MEM_LAT - 1)) begin
              tcnt  <= '0;
              state <= S_FINAL;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        S_FINAL: state <= (TREE_LAT == 0) ? S_UPD : S_TREE;
        S_TREE: begin
          if (tcnt == TW'(TREE_LAT - 1)) begin
            tcnt  <= '0;
            state <= S_UPD;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_UPD: begin
          if (px == X_LAST) begin
            px <= '0;
            if (py == Y_LAST) begin
              py    <= '0;
              state <= S_DONE;
            end else begin
              py    <= py + 1'b1;
              state <= S_START;
            end
          end else begin
            px    <= px + 1'b1;
            state <= S_START;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (load_addr) begin
        xf_q <= px + 7'(a_col);
        xg_q <= px + ((32'(a_col) >= 32'(WIN_W - 1)) ? 7'(WIN_W - 1) : 7'(a_col));
        y_q  <= py + 4'(a_row);
      end
    end
  end

  assign raw_work  = (state == S_SCAN);
  assign raw_valid = raw_work && (32'(col) < 32'(WIN_W));

  if (MEM_LAT == 0) begin : g_nodly
    assign work_d  = raw_work;
    assign valid_d = raw_valid;
  end else begin : g_dly
    logic [MEM_LAT-1:0] work_sr;
    logic [MEM_LAT-1:0] valid_sr;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        work_sr  <= '0;
        valid_sr <= '0;
      end else if (!freeze) begin
        work_sr[0]  <= raw_work;
        valid_sr[0] <= raw_valid;
        for (int unsigned i = 1; i < MEM_LAT; i++) begin
          work_sr[i]  <= work_sr[i-1];
          valid_sr[i] <= valid_sr[i-1];
        end
      end
    end

    assign work_d  = work_sr[MEM_LAT-1];
    assign valid_d = valid_sr[MEM_LAT-1];
  end

  assign bus.busy       = (state != S_IDLE);
  assign bus.done       = (state == S_DONE);
  assign bus.startsig   = (state == S_START);
  assign bus.finalstart = (state == S_FINAL);
  assign bus.update     = (state == S_UPD);
  assign bus.work       = work_d && !freeze;
  assign bus.valid      = valid_d && !freeze;
  assign bus.vector_xf  = xf_q;
  assign bus.vector_xg  = xg_q;
  assign bus.vector_y   = y_q;
  assign bus.pix_x      = px;
  assign bus.pix_y      = py;

endmodule

// File: tb/tb_match_scan_ctrl.sv
// Self-checking bench for match_scan_ctrl: single-pixel frame (20x5) and a 3x2-pixel frame (22x6).
// Stall checks are compiled in when MATCH_SCAN_STALL_EN is defined.
module tb_match_scan_ctrl;

  typedef struct {
    int k;
    int busy, startsig, work, valid, finalstart, update, done;
    int xf, xg, y;
  } tv_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  match_scan_ctrl_if one_if ();
  match_scan_ctrl_if multi_if ();

  match_scan_ctrl #(.IMG_W(20), .IMG_H(5)) u_one (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (one_if)
  );

  match_scan_ctrl #(.IMG_W(22), .IMG_H(6)) u_multi (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (multi_if)
  );

  int  n_cmp = 0;
  int  n_bad = 0;
  tv_t tbl [17];
  tv_t cap [0:121];
  int  exp_q [$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic tv_t snap_one(input int k);
    tv_t s;
    s.k = k;
    s.busy = one_if.busy;           s.startsig = one_if.startsig;
    s.work = one_if.work;           s.valid = one_if.valid;
    s.finalstart = one_if.finalstart;
    s.update = one_if.update;       s.done = one_if.done;
    s.xf = one_if.vector_xf;        s.xg = one_if.vector_xg;   s.y = one_if.vector_y;
    return s;
  endfunction

  function automatic tv_t snap_multi(input int k);
    tv_t s;
    s.k = k;
    s.busy = multi_if.busy;         s.startsig = multi_if.startsig;
    s.work = multi_if.work;         s.valid = multi_if.valid;
    s.finalstart = multi_if.finalstart;
    s.update = multi_if.update;     s.done = multi_if.done;
    s.xf = multi_if.vector_xf;      s.xg = multi_if.vector_xg; s.y = multi_if.vector_y;
    return s;
  endfunction

  task automatic cmp_rec(input string tag, input tv_t a, input tv_t e);
    chk({tag, " busy"}, a.busy, e.busy);
    chk({tag, " startsig"}, a.startsig, e.startsig);
    chk({tag, " work"}, a.work, e.work);
    chk({tag, " valid"}, a.valid, e.valid);
    chk({tag, " finalstart"}, a.finalstart, e.finalstart);
    chk({tag, " update"}, a.update, e.update);
    chk({tag, " done"}, a.done, e.done);
    chk({tag, " vector_xf"}, a.xf, e.xf);
    chk({tag, " vector_xg"}, a.xg, e.xg);
    chk({tag, " vector_y"}, a.y, e.y);
  endtask

  // Captures the single-pixel DUT for k=-1..120 relative to the startsig cycle (k=0).
  // start is re-pulsed mid-scan (k=50) and in the done cycle (k=108); both must be ignored.
  task automatic run_one(input int st_lo, input int st_hi);
    one_if.start = 1'b1;
    @(negedge clk);
    cap[0] = snap_one(-1);
    @(posedge clk); #1;
    for (int k = 0; k <= 120; k++) begin
`ifdef MATCH_SCAN_STALL_EN
      one_if.stall = (k >= st_lo && k <= st_hi);
`else
      if (st_lo > st_hi) one_if.start = 1'b0;
`endif
      one_if.start = (k == 50 || k == 108);
      @(negedge clk);
      cap[k+1] = snap_one(k);
      @(posedge clk); #1;
    end
    one_if.start = 1'b0;
`ifdef MATCH_SCAN_STALL_EN
    one_if.stall = 1'b0;
`endif
  endtask

  // Raster frame on the 3x2-pixel DUT, with a scoreboard of expected (pix_x,pix_y) per update.
  task automatic run_frame(input string tag);
    int n_upd, n_done, last_upd, tail, sx, sy, e;
    for (int y = 0; y <= 1; y++)
      for (int x = 0; x <= 2; x++)
        exp_q.push_back((x << 8) | y);
    n_upd = 0; n_done = 0; last_upd = -1; tail = -1; sx = -1; sy = -1;
    multi_if.start = 1'b1;
    @(posedge clk); #1;
    multi_if.start = 1'b0;
    for (int t = 0; t < 6 * 108 + 40; t++) begin
      @(negedge clk);
      if (multi_if.startsig) begin
        sx = multi_if.pix_x;
        sy = multi_if.pix_y;
      end
      if (multi_if.update) begin
        n_upd++;
        if (exp_q.size() == 0) begin
          chk({tag, " unexpected update"}, n_upd, 6);
        end else begin
          e = exp_q.pop_front();
          chk({tag, " pix_x"}, multi_if.pix_x, e >> 8);
          chk({tag, " pix_y"}, multi_if.pix_y, e & 255);
        end
        chk({tag, " pix_x stable START..UPD"}, multi_if.pix_x, sx);
        chk({tag, " pix_y stable START..UPD"}, multi_if.pix_y, sy);
        if (last_upd >= 0) chk({tag, " update spacing"}, t - last_upd, 108);
        last_upd = t;
      end
      if (multi_if.done) begin
        n_done++;
        if (tail < 0) tail = t + 5;
      end
      if (t == tail) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk({tag, " update count"}, n_upd, 6);
    chk({tag, " done count"}, n_done, 1);
    chk({tag, " scoreboard left"}, exp_q.size(), 0);
    chk({tag, " busy after done"}, multi_if.busy, 0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tv_t z;
    int  cnt_w, cnt_v, cnt_v5, n_ss, n_fs, n_up, n_dn;

    //          k   busy ss wk vl fs up dn  xf  xg  y
    tbl[0]  = '{-1,  0,  0, 0, 0, 0, 0, 0,  0,  0, 0};
    tbl[1]  = '{ 0,  1,  1, 0, 0, 0, 0, 0,  0,  0, 0};
    tbl[2]  = '{ 1,  1,  0, 0, 0, 0, 0, 0,  0,  0, 0};
    tbl[3]  = '{ 2,  1,  0, 1, 1, 0, 0, 0,  1,  1, 0};
    tbl[4]  = '{ 6,  1,  0, 1, 1, 0, 0, 0,  5,  4, 0};
    tbl[5]  = '{ 7,  1,  0, 1, 0, 0, 0, 0,  6,  4, 0};
    tbl[6]  = '{20,  1,  0, 1, 0, 0, 0, 0, 19,  4, 0};
    tbl[7]  = '{21,  1,  0, 1, 0, 0, 0, 0,  0,  0, 1};
    tbl[8]  = '{22,  1,  0, 1, 1, 0, 0, 0,  1,  1, 1};
    tbl[9]  = '{100, 1,  0, 1, 0, 0, 0, 0, 19,  4, 4};
    tbl[10] = '{101, 1,  0, 1, 0, 0, 0, 0, 19,  4, 4};
    tbl[11] = '{102, 1,  0, 0, 0, 1, 0, 0, 19,  4, 4};
    tbl[12] = '{103, 1,  0, 0, 0, 0, 0, 0, 19,  4, 4};
    tbl[13] = '{107, 1,  0, 0, 0, 0, 1, 0, 19,  4, 4};
    tbl[14] = '{108, 1,  0, 0, 0, 0, 0, 1, 19,  4, 4};
    tbl[15] = '{109, 0,  0, 0, 0, 0, 0, 0, 19,  4, 4};
    tbl[16] = '{110, 0,  0, 0, 0, 0, 0, 0, 19,  4, 4};

    one_if.start = 1'b0;
    multi_if.start = 1'b0;
`ifdef MATCH_SCAN_STALL_EN
    one_if.stall = 1'b0;
    multi_if.stall = 1'b0;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    z = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    cmp_rec("reset one", snap_one(0), z);
    cmp_rec("reset multi", snap_multi(0), z);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single pixel: timing table, address sweep and strobe counts.
    run_one(1, 0);
    for (int i = 0; i < 17; i++)
      cmp_rec($sformatf("one k=%0d", tbl[i].k), cap[tbl[i].k + 1], tbl[i]);

    for (int k = 1; k <= 20; k++) begin
      chk($sformatf("sweep xf k=%0d", k), cap[k+1].xf, k - 1);
      chk($sformatf("sweep xg k=%0d", k), cap[k+1].xg, (k - 1 < 4) ? k - 1 : 4);
      chk($sformatf("sweep y k=%0d", k), cap[k+1].y, 0);
    end

    for (int r = 0; r < 5; r++) begin
      cnt_w = 0; cnt_v = 0; cnt_v5 = 0;
      for (int k = 2 + 20 * r; k <= 21 + 20 * r; k++) begin
        cnt_w += cap[k+1].work;
        cnt_v += cap[k+1].valid;
        if (k <= 6 + 20 * r) cnt_v5 += cap[k+1].valid;
      end
      chk($sformatf("row %0d work count", r), cnt_w, 20);
      chk($sformatf("row %0d valid count", r), cnt_v, 5);
      chk($sformatf("row %0d valid leading", r), cnt_v5, 5);
    end

    n_ss = 0; n_fs = 0; n_up = 0; n_dn = 0; cnt_w = 0;
    for (int i = 0; i <= 121; i++) begin
      n_ss += cap[i].startsig;
      n_fs += cap[i].finalstart;
      n_up += cap[i].update;
      n_dn += cap[i].done;
      cnt_w += cap[i].work;
    end
    chk("one startsig pulses", n_ss, 1);
    chk("one finalstart pulses", n_fs, 1);
    chk("one update pulses", n_up, 1);
    chk("one done pulses", n_dn, 1);
    chk("one total work cycles", cnt_w, 100);

`ifdef MATCH_SCAN_STALL_EN
    // Stall for 3 cycles while c=7 (k=8): addresses hold, work gated, tail shifted by 3.
    run_one(8, 10);
    for (int k = 8; k <= 11; k++) chk($sformatf("stall xf k=%0d", k), cap[k+1].xf, 7);
    chk("stall xf resumes", cap[13].xf, 8);
    for (int k = 8; k <= 10; k++) chk($sformatf("stall work k=%0d", k), cap[k+1].work, 0);
    chk("stall work resumes", cap[12].work, 1);
    chk("stall finalstart unshifted slot", cap[103].finalstart, 0);
    chk("stall finalstart shifted", cap[106].finalstart, 1);
    chk("stall update shifted", cap[111].update, 1);
    chk("stall done shifted", cap[112].done, 1);
`endif

    // Reset asserted mid-scan: everything clears and no done follows.
    multi_if.start = 1'b1;
    @(posedge clk); #1;
    multi_if.start = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("midscan busy before reset", multi_if.busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    cmp_rec("midscan reset", snap_multi(0), z);
    chk("midscan reset pix_x", multi_if.pix_x, 0);
    chk("midscan reset pix_y", multi_if.pix_y, 0);
    rst_n = 1'b1;
    n_dn = 0; n_ss = 0; cnt_w = 0;
    for (int t = 0; t < 250; t++) begin
      @(negedge clk);
      n_dn += multi_if.done;
      n_ss += multi_if.startsig;
      cnt_w += multi_if.busy;
    end
    @(posedge clk); #1;
    chk("post reset done pulses", n_dn, 0);
    chk("post reset startsig pulses", n_ss, 0);
    chk("post reset busy cycles", cnt_w, 0);

    // Full frame twice; the second start from IDLE must restart at (0,0).
    run_frame("frame1");
    run_frame("frame2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
